handshake_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream handshake channel among NUM_INPUTS upstream producers, such as constant sources, loads or compute units that feed a single shared consumer. Each cycle it grants at most one valid input, latches that input's data and index into a one-slot output register, and presents them on the shared output channel. It sits between the producers and the shared resource in the dataflow circuit. Its guarantees are fairness, full throughput and no token loss or duplication.

---
 rtl/handshake_rr_arbiter_if.sv | 29 ++
 rtl/handshake_rr_arbiter.sv | 148 ++++++++++++++
 tb/tb_handshake_rr_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/handshake_rr_arbiter_if.sv
// Handshake bundle shared by the round-robin arbiter and its environment.
//   ins / ins_valid / ins_ready : NUM_INPUTS upstream producer channels,
//                                 payload i at ins[i*DATA_WIDTH +: DATA_WIDTH]
//   outs / index / outs_valid / outs_ready : single shared downstream channel
// master : environment side (drives producer payloads and consumer ready)
// slave  : arbiter side
interface handshake_rr_arbiter_if #(
    parameter int NUM_INPUTS  = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 1
);
    logic [NUM_INPUTS*DATA_WIDTH-1:0] ins;
    logic [NUM_INPUTS-1:0]            ins_valid;
    logic [NUM_INPUTS-1:0]            ins_ready;
    logic [DATA_WIDTH-1:0]            outs;
    logic [INDEX_WIDTH-1:0]           index;
    logic                             outs_valid;
    logic                             outs_ready;

    modport master (
        output ins, ins_valid, outs_ready,
        input  ins_ready, outs, index, outs_valid
    );

    modport slave (
        input  ins, ins_valid, outs_ready,
        output ins_ready, outs, index, outs_valid
    );
endinterface

// File: rtl/handshake_rr_arbiter.sv
// Round-robin arbiter: grants at most one valid producer per cycle into a
// one-slot output register that feeds a shared consumer.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset (clears the slot and the pointer)
//   bus  : slave modport of handshake_rr_arbiter_if (producer channels in,
//          registered outs/index/outs_valid out, outs_ready in)
// The search order starts at ptr_q and wraps, so the channel after the last
// winner has highest priority; ptr_q only moves when a token is accepted.
module handshake_rr_arbiter #(
    parameter int NUM_INPUTS  = 2,
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    handshake_rr_arbiter_if.slave      bus
);

    localparam int IDXW1 = INDEX_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] IDX_LAST = INDEX_WIDTH'(NUM_INPUTS - 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic [INDEX_WIDTH-1:0]  index_q, index_d;
    logic [INDEX_WIDTH-1:0]  ptr_q, ptr_d;

    logic                    found_s;
    logic [INDEX_WIDTH-1:0]  grant_idx_s;
    logic [DATA_WIDTH-1:0]   grant_data_s;
    logic [IDXW1-1:0]        dist_s;
    logic [IDXW1-1:0]        best_dist_s;
    logic                    can_load_s;
    logic                    load_s;

    // Reset gates can_load so no ready is offered while rst is low.
    assign can_load_s = rst & ((state_q == ST_EMPTY) | bus.outs_ready);
    assign load_s     = found_s & can_load_s;

    // Grant search: pick the valid channel with the smallest wrapped distance
    // from ptr_q; distance is computed in one extra bit so i+N never overflows.
    always_comb begin
        found_s      = 1'b0;
        grant_idx_s  = '0;
        grant_data_s = '0;
        best_dist_s  = '1;
        dist_s       = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (IDXW1'(i) >= {1'b0, ptr_q}) begin
                dist_s = IDXW1'(i) - {1'b0, ptr_q};
            end else begin
                dist_s = IDXW1'(i) + IDXW1'(NUM_INPUTS) - {1'b0, ptr_q};
            end
            if (bus.ins_valid[i] && (!found_s || (dist_s < best_dist_s))) begin
                found_s      = 1'b1;
                best_dist_s  = dist_s;
                grant_idx_s  = INDEX_WIDTH'(i);
                grant_data_s = bus.ins[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                found_s      = found_s;
            end
        end
    end

    // Ready decode: at most the granted channel sees ready, and only when
    // the slot can take a token this cycle.
    always_comb begin
        bus.ins_ready = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (load_s && (grant_idx_s == INDEX_WIDTH'(i))) begin
                bus.ins_ready[i] = 1'b1;
            end else begin
                bus.ins_ready[i] = 1'b0;
            end
        end
    end

    // Next-state logic for the slot FSM, payload/index registers and pointer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        index_d = index_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_EMPTY: begin
                if (load_s) begin
                    state_d = ST_FULL;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // A simultaneous drain and load keeps the slot full with
                // the new token replacing the old one.
                if (load_s) begin
                    state_d = ST_FULL;
                end else if (bus.outs_ready) begin
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (load_s) begin
            data_d  = grant_data_s;
            index_d = grant_idx_s;
            // Explicit wrap keeps ptr below NUM_INPUTS for non-power-of-2 counts.
            if (grant_idx_s == IDX_LAST) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx_s + IDX_ONE;
            end
        end else begin
            data_d  = data_q;
            index_d = index_q;
            ptr_d   = ptr_q;
        end
    end

    // State register with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            index_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            index_q <= index_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.outs       = data_q;
    assign bus.index      = index_q;
    assign bus.outs_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
module tb_handshake_rr_arbiter;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    handshake_rr_arbiter_if #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

    handshake_rr_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [N-1:0]  valid;
        logic          ordy;
        logic [N-1:0]  exp_ready;
        logic          exp_ov;
        logic [DW-1:0] exp_outs;
        logic [IW-1:0] exp_idx;
    } vec_t;

    vec_t vecs[21];

    // reference model: spec rules with plain arithmetic
    function automatic int model_grant(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    logic [DW-1:0] pd[N];
    logic [N-1:0]  pv;
    int            wait_cnt[N];
    logic [DW-1:0] q_data[$];
    int            q_idx[$];
    int            m_ptr;
    logic          m_full;

    task automatic set_payloads();
        for (int i = 0; i < N; i++) bus.ins[i*DW +: DW] = pd[i];
    endtask

    initial begin
        // inputs, then ready after them, then outs after the edge
        vecs[0]  = '{3'b111, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0};
        vecs[1]  = '{3'b111, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1};
        vecs[2]  = '{3'b111, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2};
        vecs[3]  = '{3'b111, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0};
        vecs[4]  = '{3'b101, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2};
        vecs[5]  = '{3'b101, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0};
        vecs[6]  = '{3'b101, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2};
        vecs[7]  = '{3'b101, 1'b1, 3'b001, 1'b1, 8'h11, 2'd0};
        vecs[8]  = '{3'b010, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1};
        vecs[9]  = '{3'b111, 1'b0, 3'b000, 1'b1, 8'h22, 2'd1};
        vecs[10] = '{3'b111, 1'b0, 3'b000, 1'b1, 8'h22, 2'd1};
        vecs[11] = '{3'b111, 1'b0, 3'b000, 1'b1, 8'h22, 2'd1};
        vecs[12] = '{3'b111, 1'b0, 3'b000, 1'b1, 8'h22, 2'd1};
        vecs[13] = '{3'b111, 1'b0, 3'b000, 1'b1, 8'h22, 2'd1};
        vecs[14] = '{3'b111, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2};
        vecs[15] = '{3'b000, 1'b1, 3'b000, 1'b0, 8'h33, 2'd2};
        vecs[16] = '{3'b010, 1'b1, 3'b010, 1'b1, 8'h22, 2'd1};
        vecs[17] = '{3'b000, 1'b1, 3'b000, 1'b0, 8'h22, 2'd1};
        vecs[18] = '{3'b000, 1'b1, 3'b000, 1'b0, 8'h22, 2'd1};
        vecs[19] = '{3'b000, 1'b1, 3'b000, 1'b0, 8'h22, 2'd1};
        vecs[20] = '{3'b101, 1'b1, 3'b100, 1'b1, 8'h33, 2'd2};

        pd[0] = 8'h11; pd[1] = 8'h22; pd[2] = 8'h33;
        set_payloads();
        bus.ins_valid  = 3'b111;
        bus.outs_ready = 1'b1;

        // reset held with every channel requesting
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs_valid", 32'(bus.outs_valid), 32'd0);
        chk("reset_ins_ready",  32'(bus.ins_ready),  32'd0);
        chk("reset_index",      32'(bus.index),      32'd0);
        chk("reset_outs",       32'(bus.outs),       32'd0);

        rst = 1'b1;
        for (int v = 0; v < 21; v++) begin
            bus.ins_valid  = vecs[v].valid;
            bus.outs_ready = vecs[v].ordy;
            #3;
            chk($sformatf("vec%0d_ins_ready", v), 32'(bus.ins_ready), 32'(vecs[v].exp_ready));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_outs_valid", v), 32'(bus.outs_valid), 32'(vecs[v].exp_ov));
            chk($sformatf("vec%0d_outs", v),       32'(bus.outs),       32'(vecs[v].exp_outs));
            chk($sformatf("vec%0d_index", v),      32'(bus.index),      32'(vecs[v].exp_idx));
        end

        // mid-operation reset while holding 0x33
        bus.ins_valid  = 3'b111;
        bus.outs_ready = 1'b0;
        #2;
        chk("midrst_pre_valid", 32'(bus.outs_valid), 32'd1);
        chk("midrst_pre_outs",  32'(bus.outs),       32'h33);
        rst = 1'b0;
        #1;
        chk("midrst_async_valid", 32'(bus.outs_valid), 32'd0);
        chk("midrst_ready_gated", 32'(bus.ins_ready),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        bus.outs_ready = 1'b1;
        #3;
        chk("midrst_first_ready", 32'(bus.ins_ready), 32'b001);
        @(posedge clk);
        #1;
        chk("midrst_first_outs",  32'(bus.outs),  32'h11);
        chk("midrst_first_index", 32'(bus.index), 32'd0);

        // random stress against the reference model
        rst = 1'b0;
        bus.ins_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ptr  = 0;
        m_full = 1'b0;
        pv     = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            int g;
            logic can;
            logic ordy;
            int dut_g;
            for (int i = 0; i < N; i++) begin
                if (!pv[i] && ($urandom_range(0, 1) == 1)) begin
                    pv[i] = 1'b1;
                    pd[i] = 8'($urandom);
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            set_payloads();
            bus.ins_valid  = pv;
            bus.outs_ready = ordy;
            #3;
            can = !m_full || ordy;
            g   = model_grant(pv, m_ptr);
            chk("rand_ins_ready", 32'(bus.ins_ready),
                (g >= 0 && can) ? (32'd1 << g) : 32'd0);
            chk("rand_outs_valid", 32'(bus.outs_valid), 32'(m_full));
            if (m_full && ordy) begin
                if (q_data.size() > 0) begin
                    chk("rand_outs",  32'(bus.outs),  32'(q_data.pop_front()));
                    chk("rand_index", 32'(bus.index), 32'(q_idx.pop_front()));
                end else begin
                    chk("rand_scoreboard_empty", 32'd1, 32'd0);
                end
            end
            // starvation bound measured on the DUT's own grants
            dut_g = -1;
            for (int i = 0; i < N; i++) begin
                if (bus.ins_valid[i] && bus.ins_ready[i]) dut_g = i;
            end
            if (dut_g >= 0) begin
                chk("rand_starvation", 32'(wait_cnt[dut_g] <= N - 1), 32'd1);
                for (int i = 0; i < N; i++) begin
                    if (i == dut_g) wait_cnt[i] = 0;
                    else if (pv[i]) wait_cnt[i]++;
                    else wait_cnt[i] = 0;
                end
            end
            @(posedge clk);
            #1;
            if (g >= 0 && can) begin
                m_full = 1'b1;
                m_ptr  = (g + 1) % N;
                q_data.push_back(pd[g]);
                q_idx.push_back(g);
                pv[g] = 1'b0;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
